// File: rtl/gru_fp_pkg.sv
// Shared definitions for the GRU floating-point datapath: FP constants and
// the encoding of the subtractor arbiter's handshake states.
package gru_fp_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_ONE     = 32'h3F800000;
    localparam logic [31:0] FP_NEG_ONE = 32'hBF800000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_RESP      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sub_arbiter_rr_picker.sv
// Rotate-priority encoder: returns the first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int j;

    // Scan from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one FP subtractor among NUM_REQ requesters over a
// 4-phase start/done handshake. Optional watchdog: define SUB_ARB_TIMEOUT_EN.
module sub_arbiter
    import gru_fp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_start,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_out,
    output logic                          req_err,
    output logic                          sub_start,
    output logic [DATA_WIDTH-1:0]         sub_a,
    output logic [DATA_WIDTH-1:0]         sub_b,
    input  logic                          sub_done,
    input  logic [DATA_WIDTH-1:0]         sub_out,
    output logic                          busy
);

    localparam int              IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("sub_arbiter: unsupported parameter set");
    end

    arb_state_t              state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req_start),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign busy = (state != S_IDLE);

`ifdef SUB_ARB_TIMEOUT_EN
    localparam int              CNT_W    = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            req_done  <= '0;
            req_out   <= '0;
            sub_start <= 1'b0;
            sub_a     <= '0;
            sub_b     <= '0;
`ifdef SUB_ARB_TIMEOUT_EN
            req_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        sub_a <= a_arr[pick_idx];
                        sub_b <= b_arr[pick_idx];
                        state <= S_START;
                    end
                end
                // A done left high by the previous user must fall before a new start.
                S_START: begin
                    if (!sub_done) begin
                        sub_start <= 1'b1;
                        state     <= S_WAIT_DONE;
`ifdef SUB_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (sub_done) begin
                        req_out   <= sub_out;
                        sub_start <= 1'b0;
                        state     <= S_WAIT_ACK;
`ifdef SUB_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
                    end else if (tmo_hit) begin
                        req_out   <= DATA_WIDTH'(FP_QNAN);
                        req_err   <= 1'b1;
                        sub_start <= 1'b0;
                        state     <= S_WAIT_ACK;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_ACK: begin
                    if (!sub_done) begin
                        req_done <= NUM_REQ'(1) << grant;
                        state    <= S_RESP;
`ifdef SUB_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        req_done <= NUM_REQ'(1) << grant;
                        req_err  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (!req_start[grant]) begin
                        req_done <= '0;
                        rr_ptr   <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                        state    <= S_IDLE;
`ifdef SUB_ARB_TIMEOUT_EN
                        req_err  <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboard bench for sub_arbiter with a behavioural FP subtractor on the shared port.
module tb_sub_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk;
    logic              rstn;
    logic [NR-1:0]     req_start;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     req_out;
    logic              req_err;
    logic              sub_start;
    logic [DW-1:0]     sub_a;
    logic [DW-1:0]     sub_b;
    logic              sub_done;
    logic [DW-1:0]     sub_out;
    logic              busy;

    sub_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_start (req_start),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_done  (req_done),
        .req_out   (req_out),
        .req_err   (req_err),
        .sub_start (sub_start),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_done  (sub_done),
        .sub_out   (sub_out),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] v;
        logic        e;
    } exp_t;

    exp_t exp_val [NR][$];
    int   exp_ord [$];
    int   wait_cnt [NR];
    bit   pending [NR];
    bit   sub_hold;
    int   n_cmp;
    int   n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic real sp_to_real(input logic [31:0] x);
        int  e;
        real m;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        for (int k = 127; k < e; k++) m = m * 2.0;
        for (int k = e; k < 127; k++) m = m / 2.0;
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_sp(input real v);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) - sp_to_real(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        int k;
        k = int'($urandom_range(0, 256)) - 128;
        return real_to_sp(real'(k) / 4.0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issues one transaction from requester i; caller is at a negedge.
    task automatic run_req(input int i, input logic [31:0] a, input logic [31:0] b, input bit tmo);
        int   n;
        exp_t e;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        e.v = tmo ? 32'h7FC00000 : fsub(a, b);
        e.e = tmo;
        exp_val[i].push_back(e);
        wait_cnt[i]  = 0;
        pending[i]   = 1'b1;
        req_start[i] = 1'b1;
        n = 0;
        while (req_done[i] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL req%0d_done_wait: got no done within %0d cycles, expected done", i, n);
        end
        req_start[i] = 1'b0;
        pending[i]   = 1'b0;
    endtask

    task automatic run_rand(input int i);
        repeat (8) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_req(i, rand_fp(), rand_fp(), 1'b0);
            @(negedge clk);
        end
    endtask

    // Behavioural subtractor with random start-to-done and ack latencies.
    initial begin
        int cnt;
        int lat;
        cnt      = 0;
        lat      = 1;
        sub_done = 1'b0;
        sub_out  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sub_done = 1'b0;
                cnt      = 0;
            end else if (!sub_done) begin
                if (sub_start && !sub_hold) begin
                    if (cnt >= lat) begin
                        sub_out  = fsub(sub_a, sub_b);
                        sub_done = 1'b1;
                        cnt      = 0;
                        lat      = int'($urandom_range(0, 3));
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!sub_start) begin
                if (cnt >= lat) begin
                    sub_done = 1'b0;
                    sub_out  = $urandom;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each rising req_done.
    initial begin
        logic [NR-1:0] prev;
        int            idx;
        exp_t          e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (req_done != '0 && prev == '0) begin
                idx = 0;
                for (int k = 0; k < NR; k++) if (req_done[k]) idx = k;
                check("done_onehot", 32'($onehot(req_done)), 32'd1);
                if (exp_val[idx].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done on req%0d, expected none", idx);
                end else begin
                    e = exp_val[idx].pop_front();
                    check($sformatf("result_req%0d", idx), req_out, e.v);
                    check($sformatf("err_req%0d", idx), 32'(req_err), 32'(e.e));
                end
                if (exp_ord.size() > 0) check("grant_order", 32'(idx), 32'(exp_ord.pop_front()));
                if (pending[idx]) check("fair_wait_ok", 32'(wait_cnt[idx] <= NR - 1), 32'd1);
                for (int k = 0; k < NR; k++) if (k != idx && pending[k]) wait_cnt[k]++;
            end else if (req_done != '0) begin
                check("done_stable", 32'(req_done), 32'(prev));
            end
            prev = req_done;
        end
    end

    initial begin
        int n;
        n_cmp     = 0;
        n_err     = 0;
        sub_hold  = 1'b0;
        rstn      = 1'b0;
        req_start = '0;
        req_a     = '0;
        req_b     = '0;
        for (int k = 0; k < NR; k++) begin
            wait_cnt[k] = 0;
            pending[k]  = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_req_out", req_out, 32'd0);
        check("rst_req_err", 32'(req_err), 32'd0);
        check("rst_sub_start", 32'(sub_start), 32'd0);
        check("rst_sub_a", sub_a, 32'd0);
        check("rst_sub_b", sub_b, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single request 3.0 - 1.0 with start latency check.
        fork
            run_req(0, 32'h40400000, 32'h3F800000, 1'b0);
            begin
                @(posedge clk); #1;
                check("start_lat_cyc1", 32'(sub_start), 32'd0);
                check("busy_after_grant", 32'(busy), 32'd1);
                @(posedge clk); #1;
                check("start_lat_cyc2", 32'(sub_start), 32'd1);
            end
        join
        @(negedge clk);

        // All four requesting continuously from reset.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_ord = '{0, 1, 2, 3, 0};
        fork
            begin
                run_req(0, rand_fp(), rand_fp(), 1'b0);
                @(negedge clk);
                run_req(0, rand_fp(), rand_fp(), 1'b0);
            end
            run_req(1, rand_fp(), rand_fp(), 1'b0);
            run_req(2, rand_fp(), rand_fp(), 1'b0);
            run_req(3, rand_fp(), rand_fp(), 1'b0);
        join
        @(negedge clk);

        // Req 2 re-asserts immediately while 3 is pending.
        exp_ord = '{2, 3, 2};
        fork
            begin
                run_req(2, rand_fp(), rand_fp(), 1'b0);
                @(negedge clk);
                run_req(2, rand_fp(), rand_fp(), 1'b0);
            end
            run_req(3, rand_fp(), rand_fp(), 1'b0);
        join
        @(negedge clk);

        // Operands change after grant; latched values 1.0 - 0.5 must be used.
        fork
            run_req(1, 32'h3F800000, 32'h3F000000, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                req_b[1*DW +: DW] = 32'h40A00000;
                req_a[1*DW +: DW] = 32'h42000000;
            end
        join
        @(negedge clk);

        // Reset while waiting on the subtractor.
        run_req(1, 32'h40200000, 32'h3F800000, 1'b0);
        @(negedge clk);
        sub_hold = 1'b1;
        req_a[3*DW +: DW] = 32'h40800000;
        req_b[3*DW +: DW] = 32'h3F800000;
        req_start[3] = 1'b1;
        n = 0;
        while (!sub_start && n < 50) begin @(negedge clk); n++; end
        check("pre_rst_in_wait", 32'(sub_start), 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_req_done", 32'(req_done), 32'd0);
        check("midrst_req_out", req_out, 32'd0);
        check("midrst_req_err", 32'(req_err), 32'd0);
        check("midrst_sub_start", 32'(sub_start), 32'd0);
        check("midrst_sub_a", sub_a, 32'd0);
        check("midrst_sub_b", sub_b, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        req_start[3] = 1'b0;
        @(negedge clk);
        sub_hold = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        exp_ord = '{0, 2};
        fork
            run_req(0, rand_fp(), rand_fp(), 1'b0);
            run_req(2, rand_fp(), rand_fp(), 1'b0);
        join
        @(negedge clk);

        // Randomized traffic from all requesters.
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
            run_rand(3);
        join
        @(negedge clk);

`ifdef SUB_ARB_TIMEOUT_EN
        // Subtractor never answers: watchdog returns qNaN with error.
        sub_hold = 1'b1;
        fork
            run_req(0, 32'h40000000, 32'h3F800000, 1'b1);
            begin
                n = 0;
                while (!sub_start && n < 50) begin @(posedge clk); #1; n++; end
                n = 0;
                while (sub_start && n < 100) begin @(posedge clk); #1; n++; end
                check("tmo_start_cycles", 32'(n), 32'd16);
            end
        join
        @(negedge clk);
        sub_hold = 1'b0;
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("order_queue_left", 32'(exp_ord.size()), 32'd0);
        for (int k = 0; k < NR; k++) check($sformatf("scoreboard_left_req%0d", k), 32'(exp_val[k].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Round-robin arbiter that shares one floating-point subtractor instance among NUM_REQ requesters, e.g. the per-unit (1 - z) and (h_prev - h_cand) operations in the GRU cell.
- Each requester sees the same 4-phase start/done handshake the subtractor itself uses.
- The arbiter sequences the shared unit's handshake and routes the result back to the granted requester.
- Sits between the GRU gate-combine controllers and a single subtractor placed alongside it at the same hierarchy level.

Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 255, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_start  in  NUM_REQ  per-requester start; held high until that requester's req_done is seen.
- req_a  in  NUM_REQ*DATA_WIDTH  minuend, requester i at bits [i*DW +: DW].
- req_b  in  NUM_REQ*DATA_WIDTH  subtrahend, same packing as req_a.
- req_done  out  NUM_REQ  one-hot done; bit i high while requester i's result is valid.
- req_out  out  DATA_WIDTH  result, valid while any req_done bit is high.
- req_err  out  1  timeout flag, qualified by req_done (tied 0 when the optional feature is off).
- sub_start  out  1  start to the shared subtractor.
- sub_a  out  DATA_WIDTH  value_a to the subtractor.
- sub_b  out  DATA_WIDTH  value_b to the subtractor.
- sub_done  in  1  done from the subtractor.
- sub_out  in  DATA_WIDTH  value_out from the subtractor.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (async, rstn low): state S_IDLE, rr_ptr=0, grant=0; outputs req_done=0, req_out=0, req_err=0, sub_start=0, sub_a=0, sub_b=0, busy=0. Reset mid-transaction abandons it with no done pulse.
- Arbitration (in S_IDLE only): search req_start starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit wins. No set bit means stay in S_IDLE.
- States:
  - S_IDLE: on a winner, latch grant=index, sub_a=req_a[grant], sub_b=req_b[grant]; go to S_START.
  - S_START: sub_start<=1; go to S_WAIT_DONE.
  - S_WAIT_DONE: hold sub_start=1. On sub_done=1, capture req_out<=sub_out, sub_start<=0, go to S_WAIT_ACK.
  - S_WAIT_ACK: sub_start=0. On sub_done=0, go to S_RESP.
  - S_RESP: req_done[grant]=1. When req_start[grant]=0, req_done<=0, rr_ptr<=(grant+1) mod NUM_REQ, go to S_IDLE.
- Latency: request-to-sub_start is 2 cycles. Arbiter overhead beyond the subtractor's own latency is at most 5 cycles per transaction, including the acknowledge cycle.
- Operands are latched once at grant. Requesters changing req_a/req_b after grant do not affect the result.
- Fairness: a requester holding req_start waits at most NUM_REQ-1 transactions.
- Corner cases:
  - Requester i re-asserting req_start in the cycle it returns to S_IDLE loses to any other pending requester, because rr_ptr has advanced past i.
  - If sub_done is already high on entry to S_START (a protocol violation from the previous use), the block waits in S_START until sub_done=0 before asserting sub_start.
  - A requester dropping req_start before its done is not supported. The transaction still completes and req_done is held until req_start is low, which means it completes immediately.
- Ungranted req_done bits are always 0. req_out holds its last value while no done is asserted.

Optional Feature:
- Macro SUB_ARB_TIMEOUT_EN.
- When defined: an 8-bit-or-wider counter runs in S_WAIT_DONE and S_WAIT_ACK.
  - In S_WAIT_DONE, reaching TIMEOUT_CYC forces sub_start<=0, req_out<=32'h7FC00000 (qNaN), req_err<=1, and transitions to S_WAIT_ACK.
  - In S_WAIT_ACK, reaching TIMEOUT_CYC goes directly to S_RESP with req_err=1.
  - req_err clears together with req_done.
- When undefined: no counter; req_err is tied 0; the block waits on sub_done indefinitely.

Decomposition:
- Shared package gru_fp_pkg holds:
  - FP constants FP_QNAN=32'h7FC00000, FP_ONE=32'h3F800000, FP_NEG_ONE=32'hBF800000;
  - the arbiter state encoding (3-bit).
- One sub-module is natural: rr_picker, a combinational rotate-priority encoder with inputs req vector and ptr, and outputs valid and index.
- The subtractor remains instantiated outside, next to the arbiter.

Test Plan:
- Single request: req 0 with a=0x40400000 (3.0), b=0x3F800000 (1.0), behavioural subtractor → req_done[0]=1, req_out=0x40000000; sub_start rises 2 cycles after req_start.
- All 4 requesting continuously from reset → grant order 0,1,2,3,0; each req_done one-hot and never overlapping.
- Req 2 finishes and re-asserts immediately while req 3 pending → req 3 served before req 2.
- Req_b changed to 0x40A00000 one cycle after grant (a=1.0, b=0.5) → result 0x3F000000 (0.5), i.e. the latched operands are used.
- rstn asserted during S_WAIT_DONE → all outputs 0 immediately, rr_ptr=0; the next request from 0 is served normally.
- With SUB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, sub_done stuck 0 → sub_start drops at cycle 16 of the wait; req_done with req_out=0x7FC00000 and req_err=1.
